// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_D = 2'd1,
    ST_BUSY_I = 2'd2
  } arb_state_e;

  localparam logic [1:0]  SIZE_WORD = 2'b11;
  localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Clearable up-counter; tc_o flags the enabled cycle that would reach Limit.
module arb_timeout_counter #(
  parameter int unsigned Width = 8,
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [Width-1:0] LastVal = Width'(Limit - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tc_o = en_i && !clear_i && (cnt_q == LastVal);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and data ports; data has priority,
// with a starvation guard for fetch and a timeout abort that sets a sticky error.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_error
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  arb_state_e  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic        if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic        bus_error_q, bus_error_d;
  logic        busy, tmo_hit;

  assign busy = (state_q != ST_IDLE);

  // Held clear while idle so the count starts from zero on every BUSY entry.
  arb_timeout_counter #(
    .Width(8),
    .Limit(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i  (clock),
    .rst_i  (reset),
    .clear_i(!busy),
    .en_i   (busy && !mem_ready),
    .tc_o   (tmo_hit)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    bus_error_d = bus_error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!if_req) starve_d = '0;
        if (dm_req && (!if_req || (starve_q < StarveLim))) begin
          state_d     = ST_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_size_d  = dm_size;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req) starve_d = sat_inc4(starve_q);
        end else if (if_req) begin
          state_d     = ST_BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_size_d  = SIZE_WORD;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end
      ST_BUSY_D, ST_BUSY_I: begin
        // A ready arriving on the timeout cycle still counts as a normal completion.
        if (mem_ready || tmo_hit) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          if (!mem_ready) bus_error_d = 1'b1;
          if (state_q == ST_BUSY_D) begin
            dm_valid_d = 1'b1;
            dm_rdata_d = !mem_ready ? ERR_DATA : (mem_we_q ? 32'h0 : mem_rdata);
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : ERR_DATA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign bus_error = bus_error_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level arbiter model.
module tb_mem_port_arbiter;

  localparam int SL  = 4;
  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, if_valid, dm_req, dm_we, dm_valid;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [1:0]  dm_size, mem_size;
  logic        mem_req, mem_we, mem_ready, stall_if, stall_mem, bus_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .STARVE_LIMIT  (SL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_size  (dm_size),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_size (mem_size),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_size = 0; dm_addr = 0; dm_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #3;
    n_checks++;
    if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata} !== 68'h0) begin
      n_fail++; $display("FAIL reset_mem: got %h expected 0", {mem_req, mem_we, mem_size, mem_addr, mem_wdata});
    end
    n_checks++;
    if ({if_valid, dm_valid, if_rdata, dm_rdata, bus_error} !== 67'h0) begin
      n_fail++; $display("FAIL reset_ports: got %h expected 0", {if_valid, dm_valid, if_rdata, dm_rdata, bus_error});
    end
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    n_checks++;
    if ({mem_req, if_valid, dm_valid, stall_if, stall_mem, bus_error} !== 6'b0) begin
      n_fail++; $display("FAIL reset_release: got %b expected 000000", {mem_req, if_valid, dm_valid, stall_if, stall_mem, bus_error});
    end
  endtask

  task automatic test_single_fetch();
    logic [31:0] d;
    @(negedge clock);
    if_req = 1; if_addr = 32'h40;
    #1;
    n_checks++;
    if (stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch_stall0: got %b expected 1", stall_if); end
    @(negedge clock);
    n_checks++;
    if ({mem_req, mem_we, mem_size, mem_addr, if_valid, stall_if} !== {1'b1, 1'b0, 2'b11, 32'h40, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL fetch_grant: got %h expected %h", {mem_req, mem_we, mem_size, mem_addr, if_valid, stall_if},
                         {1'b1, 1'b0, 2'b11, 32'h40, 1'b0, 1'b1});
    end
    d = $urandom; mem_ready = 1; mem_rdata = d;
    @(negedge clock);
    n_checks++;
    if ({if_valid, if_rdata, mem_req, stall_if, dm_valid} !== {1'b1, d, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL fetch_done: got %h expected %h", {if_valid, if_rdata, mem_req, stall_if, dm_valid},
                         {1'b1, d, 1'b0, 1'b0, 1'b0});
    end
    if_req = 0; mem_ready = 0;
    @(negedge clock);
    n_checks++;
    if ({if_valid, mem_req} !== 2'b00) begin n_fail++; $display("FAIL fetch_pulse: got %b expected 00", {if_valid, mem_req}); end
  endtask

  task automatic test_write();
    @(negedge clock);
    dm_req = 1; dm_we = 1; dm_addr = 32'h1000; dm_wdata = 32'hCAFEF00D; dm_size = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata, dm_valid, stall_mem} !==
          {1'b1, 1'b1, 2'b01, 32'h1000, 32'hCAFEF00D, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL write_hold%0d: got %h expected %h", i,
                           {mem_req, mem_we, mem_size, mem_addr, mem_wdata, dm_valid, stall_mem},
                           {1'b1, 1'b1, 2'b01, 32'h1000, 32'hCAFEF00D, 1'b0, 1'b1});
      end
    end
    mem_ready = 1; mem_rdata = 32'h12345678;
    @(negedge clock);
    n_checks++;
    if ({dm_valid, dm_rdata, mem_req, if_valid} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL write_done: got %h expected %h", {dm_valid, dm_rdata, mem_req, if_valid}, {1'b1, 32'h0, 1'b0, 1'b0});
    end
    dm_req = 0; dm_we = 0; mem_ready = 0;
    @(negedge clock);
  endtask

  task automatic test_ignored();
    @(negedge clock);
    mem_ready = 1; mem_rdata = 32'h5555AAAA;
    @(negedge clock);
    mem_ready = 0;
    n_checks++;
    if ({if_valid, dm_valid, mem_req} !== 3'b000) begin
      n_fail++; $display("FAIL idle_ready: got %b expected 000", {if_valid, dm_valid, mem_req});
    end
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; dm_size = 2'b10;
    @(negedge clock);
    dm_addr = 32'h555; dm_we = 1; dm_size = 2'b00;
    @(negedge clock);
    n_checks++;
    if ({mem_req, mem_we, mem_size, mem_addr} !== {1'b1, 1'b0, 2'b10, 32'h300}) begin
      n_fail++; $display("FAIL busy_latch: got %h expected %h", {mem_req, mem_we, mem_size, mem_addr}, {1'b1, 1'b0, 2'b10, 32'h300});
    end
    mem_ready = 1; mem_rdata = 32'h0BADF00D;
    @(negedge clock);
    n_checks++;
    if ({dm_valid, dm_rdata} !== {1'b1, 32'h0BADF00D}) begin
      n_fail++; $display("FAIL busy_latch_done: got %h expected %h", {dm_valid, dm_rdata}, {1'b1, 32'h0BADF00D});
    end
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_starvation();
    logic [9:0] exp_fetch;
    int g;
    logic prev;
    exp_fetch = 10'b10_0001_0000;
    g = 0; prev = 0;
    do_reset();
    if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_size = 2'b10; dm_addr = 32'h200;
    for (int c = 0; c < 100 && g < 10; c++) begin
      @(negedge clock);
      if (mem_req && !prev) begin
        n_checks++;
        if (mem_addr !== (exp_fetch[g] ? 32'h100 : 32'h200)) begin
          n_fail++; $display("FAIL starve_grant%0d: got addr %h expected %h", g, mem_addr, exp_fetch[g] ? 32'h100 : 32'h200);
        end
        g++;
      end
      prev = mem_req;
      mem_ready = mem_req;
    end
    n_checks++;
    if (g != 10) begin n_fail++; $display("FAIL starve_count: got %0d grants expected 10", g); end
    if_req = 0; dm_req = 0;
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_random(input int ncyc);
    logic busy, was_busy, exp_done, if_pend, dm_pend;
    logic p_if, p_dm, p_we, g_dm, g_we;
    logic [1:0] p_sz;
    logic [31:0] p_ia, p_da, p_wd, g_addr, exp_rd;
    int starve, wait_cnt, delay, want;
    do_reset();
    busy = 0; exp_done = 0; if_pend = 0; dm_pend = 0; p_if = 0; p_dm = 0; p_we = 0; p_sz = 0;
    p_ia = 0; p_da = 0; p_wd = 0; g_dm = 0; g_we = 0; g_addr = 0; exp_rd = 0;
    starve = 0; wait_cnt = 0; delay = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      n_checks++;
      if ({stall_if, stall_mem} !== {if_req & ~if_valid, dm_req & ~dm_valid}) begin
        n_fail++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, {stall_if, stall_mem}, {if_req & ~if_valid, dm_req & ~dm_valid});
      end
      was_busy = busy;
      if (exp_done) begin
        busy = 0;
        n_checks++;
        if ({mem_req, if_valid, dm_valid, (g_dm ? dm_rdata : if_rdata)} !== {1'b0, ~g_dm, g_dm, exp_rd}) begin
          n_fail++; $display("FAIL rnd_done c%0d: got %h expected %h", c,
                             {mem_req, if_valid, dm_valid, (g_dm ? dm_rdata : if_rdata)}, {1'b0, ~g_dm, g_dm, exp_rd});
        end
        if (g_dm) dm_pend = 0; else if_pend = 0;
      end else begin
        n_checks++;
        if ({if_valid, dm_valid} !== 2'b00) begin
          n_fail++; $display("FAIL rnd_spurious_valid c%0d: got %b expected 00", c, {if_valid, dm_valid});
        end
        if (!was_busy) begin
          want = (p_dm && (!p_if || starve < SL)) ? 1 : (p_if ? 2 : 0);
          if (!p_if) starve = 0;
          else if (want == 1) starve = (starve < 15) ? starve + 1 : 15;
          else if (want == 2) starve = 0;
          n_checks++;
          if (mem_req !== (want != 0)) begin
            n_fail++; $display("FAIL rnd_grant c%0d: got mem_req %b expected %b", c, mem_req, want != 0);
          end
          if (want != 0) begin
            busy = 1; g_dm = (want == 1); g_we = g_dm ? p_we : 1'b0; g_addr = g_dm ? p_da : p_ia;
            n_checks++;
            if ({mem_we, mem_size, mem_addr} !== {g_we, (g_dm ? p_sz : 2'b11), g_addr}) begin
              n_fail++; $display("FAIL rnd_fields c%0d: got %h expected %h", c, {mem_we, mem_size, mem_addr},
                                 {g_we, (g_dm ? p_sz : 2'b11), g_addr});
            end
            if (g_we) begin
              n_checks++;
              if (mem_wdata !== p_wd) begin
                n_fail++; $display("FAIL rnd_wdata c%0d: got %h expected %h", c, mem_wdata, p_wd);
              end
            end
            wait_cnt = 0; delay = $urandom_range(0, 4);
          end
        end else begin
          n_checks++;
          if ({mem_req, mem_addr} !== {1'b1, g_addr}) begin
            n_fail++; $display("FAIL rnd_hold c%0d: got %h expected %h", c, {mem_req, mem_addr}, {1'b1, g_addr});
          end
        end
      end
      exp_done = 0;
      mem_rdata = $urandom;
      mem_ready = 0;
      if (busy) begin
        if (wait_cnt == delay) begin
          mem_ready = 1; exp_done = 1; exp_rd = g_we ? 32'h0 : mem_rdata;
        end else begin
          wait_cnt++;
        end
      end
      if (!if_pend) begin
        if ($urandom_range(0, 2) != 0) begin if_pend = 1; if_req = 1; if_addr = $urandom; end
        else if_req = 0;
      end
      if (!dm_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          dm_pend = 1; dm_req = 1; dm_we = 1'($urandom); dm_size = 2'($urandom);
          dm_addr = $urandom; dm_wdata = $urandom;
        end else dm_req = 0;
      end
      p_if = if_req; p_dm = dm_req; p_we = dm_we; p_sz = dm_size;
      p_ia = if_addr; p_da = dm_addr; p_wd = dm_wdata;
    end
    n_checks++;
    if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rnd_bus_error: got %b expected 0", bus_error); end
    do_reset();
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clock);
    dm_req = 1; dm_we = 1; dm_addr = 32'h7000; dm_wdata = 32'h11223344; dm_size = 2'b11;
    @(negedge clock);
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL areset_busy: got %b expected 1", mem_req); end
    #2 reset = 1;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata, dm_valid, if_valid, bus_error} !== 71'h0) begin
      n_fail++; $display("FAIL areset_outputs: got %h expected 0",
                         {mem_req, mem_we, mem_size, mem_addr, mem_wdata, dm_valid, if_valid, bus_error});
    end
    dm_req = 0; mem_ready = 1;
    @(negedge clock);
    reset = 0; mem_ready = 0;
    begin
      logic seen;
      seen = 0;
      repeat (3) begin @(negedge clock); seen |= dm_valid | if_valid | mem_req; end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL areset_dropped: got %b expected 0", seen); end
    end
    dm_req = 1; dm_we = 0; dm_addr = 32'h7004;
    @(negedge clock);
    mem_ready = 1; mem_rdata = 32'hA5A5_0101;
    @(negedge clock);
    n_checks++;
    if ({dm_valid, dm_rdata} !== {1'b1, 32'hA5A5_0101}) begin
      n_fail++; $display("FAIL areset_fresh: got %h expected %h", {dm_valid, dm_rdata}, {1'b1, 32'hA5A5_0101});
    end
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int busy_cycles;
    do_reset();
    @(negedge clock);
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_size = 2'b11;
    @(negedge clock);
    busy_cycles = mem_req ? 1 : 0;
    for (int i = 0; i < 20 && dm_valid !== 1'b1; i++) begin
      @(negedge clock);
      if (mem_req === 1'b1) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles != TMO) begin n_fail++; $display("FAIL tmo_cycles: got %0d expected %0d", busy_cycles, TMO); end
    n_checks++;
    if ({dm_valid, dm_rdata, bus_error, mem_req} !== {1'b1, 32'hDEADBEEF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL tmo_abort: got %h expected %h", {dm_valid, dm_rdata, bus_error, mem_req},
                         {1'b1, 32'hDEADBEEF, 1'b1, 1'b0});
    end
    dm_req = 0;
    @(negedge clock);
    if_req = 1; if_addr = 32'h80;
    @(negedge clock);
    mem_ready = 1; mem_rdata = 32'h0000_1111;
    @(negedge clock);
    n_checks++;
    if ({if_valid, if_rdata, bus_error} !== {1'b1, 32'h0000_1111, 1'b1}) begin
      n_fail++; $display("FAIL tmo_sticky: got %h expected %h", {if_valid, if_rdata, bus_error}, {1'b1, 32'h0000_1111, 1'b1});
    end
    idle_inputs();
    reset = 1;
    #1;
    n_checks++;
    if (bus_error !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", bus_error); end
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write();
    test_ignored();
    test_starvation();
    test_random(800);
    test_async_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch stage and the MEM-stage data port of the 5-stage MIPS pipeline.
- Data port has fixed priority over fetch; a starvation guard forces a fetch grant after a bounded number of back-to-back data grants.
- Produces per-port stall signals that hold the PC, IF/ID and MEM-stage registers while a port waits, plus a timeout abort with a sticky error flag.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced; legal range 1-15.
- TIMEOUT_CYCLES, 255, BUSY cycles without mem_ready before the transaction is aborted; legal range 2-255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_valid.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word.
- if_valid  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request, level; held until dm_valid.
- dm_we  in  1  1 = write, 0 = read.
- dm_size  in  2  access size, passed through unchanged.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; 0 on write completion.
- dm_valid  out  1  one-cycle completion pulse for data.
- mem_req  out  1  request to backing memory, registered.
- mem_we  out  1  registered write enable.
- mem_size  out  2  registered size.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered write data.
- mem_rdata  in  32  memory read data; valid when mem_ready = 1.
- mem_ready  in  1  memory completion strobe.
- stall_if  out  1  if_req & ~if_valid, combinational.
- stall_mem  out  1  dm_req & ~dm_valid, combinational.
- bus_error  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - All registered outputs go to 0: mem_* outputs, if_rdata, dm_rdata, if_valid, dm_valid, bus_error.
  - starve_cnt and tmo_cnt go to 0.
  - An in-flight transaction is dropped with no valid pulse.
- FSM states:
  - IDLE: arbitrate.
  - BUSY_D: data transaction outstanding.
  - BUSY_I: fetch transaction outstanding.
- IDLE arbitration, evaluated every cycle:
  - If dm_req and (!if_req or starve_cnt < STARVE_LIMIT): grant data and go to BUSY_D.
  - Else if if_req: grant fetch and go to BUSY_I.
  - Else stay in IDLE.
- On the grant edge:
  - Latch the granted port's addr, we, size and wdata into mem_*.
  - Assert mem_req. A fetch grant forces mem_we = 0 and mem_size = 2'b11.
- BUSY states:
  - mem_req stays 1 and mem_* stay stable until mem_ready is sampled 1.
  - On that edge: capture mem_rdata into the granted port's rdata (dm_rdata = 0 for writes), pulse that port's valid for exactly one cycle, drop mem_req, and return to IDLE.
- Latency:
  - Request seen in IDLE at edge N gives mem_req high after N; mem_ready at edge N+1 gives valid high after N+1.
  - Minimum 2 cycles from request to valid.
  - Back-to-back: the cycle in which valid is high is an IDLE cycle. The next grant can occur at the following edge, so mem_req stays low for one cycle between transactions.
- Timeout:
  - tmo_cnt clears on entry to a BUSY state and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES: abort, pulse the port's valid with rdata = 32'hDEADBEEF, set bus_error, return to IDLE, drop mem_req.
  - If mem_ready arrives in the same cycle as the timeout, it wins as a normal completion.
- Starvation counter (starve_cnt, 4 bits, saturating at 15):
  - +1 on each data grant while if_req = 1.
  - Cleared on a fetch grant, or in any IDLE cycle with if_req = 0.
- Simultaneous requests in IDLE with starve_cnt < STARVE_LIMIT: data wins.
- Ignored inputs: mem_ready in IDLE; request/address changes while a BUSY state is active (latched values are used).
- Requester drops its req mid-transaction: the transaction still completes and valid still pulses; the requester ignores it.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encoding: ST_IDLE = 2'd0, ST_BUSY_D = 2'd1, ST_BUSY_I = 2'd2.
  - SIZE_WORD = 2'b11.
  - ERR_DATA = 32'hDEADBEEF.
- One sub-module, arb_timeout_counter: clear / enable / terminal-count counter reused for tmo_cnt.
- Arbitration and FSM stay in the top module.

Test Plan:
- Single fetch, if_addr = 32'h40, mem_ready one cycle after mem_req -> mem_req high 1 cycle; if_valid on cycle 2 with if_rdata = mem_rdata; mem_we = 0; stall_if high for cycles 0-1.
- dm_req and if_req asserted together, STARVE_LIMIT = 4, dm_req held continuously -> 4 data grants, then 1 fetch grant, then data again; starve_cnt back to 0 after the fetch grant.
- Write dm_addr = 32'h1000, dm_wdata = 32'hCAFEF00D, dm_size = 2'b01 -> mem_we = 1, mem_size = 01, mem_wdata = CAFEF00D held until mem_ready; dm_valid pulses with dm_rdata = 0.
- mem_ready never asserted, TIMEOUT_CYCLES = 8 -> abort after 8 BUSY cycles; dm_valid pulse with dm_rdata = DEADBEEF; bus_error stays 1 until reset.
- Reset asserted asynchronously mid-BUSY_D (between edges) -> mem_req and all outputs go to 0 immediately; no dm_valid; after release, a fresh request completes normally.
- mem_ready pulses while in IDLE, and dm_addr changes during BUSY -> no valid pulse; mem_addr keeps the latched value.
